// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: shared types and helpers for the HDMI video timing path.
// Holds the pixel/coordinate types, the raster FSM state encoding and the
// colour-bar lookup used by the optional test pattern.
package hdmi_video_pkg;

  localparam int COORD_W = 12;

  // Raster coordinate (column or line), unsigned.
  typedef logic [COORD_W-1:0] coord_t;

  // One pixel as presented on the ADV7513 parallel bus: {R,G,B}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Raster FSM: IDLE holds counters at 0, RUN scans whole frames.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Classic 8-bar pattern, left to right.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF; // white
      3'd1:    c = 24'hFFFF00; // yellow
      3'd2:    c = 24'h00FFFF; // cyan
      3'd3:    c = 24'h00FF00; // green
      3'd4:    c = 24'hFF00FF; // magenta
      3'd5:    c = 24'hFF0000; // red
      3'd6:    c = 24'h0000FF; // blue
      default: c = 24'h000000; // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_colour_bars.sv
// video_colour_bars: maps a requested column to one of 8 vertical colour bars.
// Purely combinational. The whole module only exists when the build defines
// HDMI_TEST_PATTERN_EN; otherwise this file is intentionally empty.
`ifdef HDMI_TEST_PATTERN_EN
module video_colour_bars
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [11:0] i_pix_x,
  output logic [23:0] o_rgb
);

  // Enough headroom for pix_x*8 without overflow.
  typedef logic [COORD_W+2:0] scaled_t;
  localparam scaled_t DIVISOR = scaled_t'(H_ACTIVE);

  scaled_t    w_scaled;
  logic [2:0] w_bar;

  // bar = pix_x*8/H_ACTIVE; only meaningful for active columns.
  assign w_scaled = {i_pix_x, 3'b000};
  assign w_bar    = 3'(w_scaled / DIVISOR);

  // Look up the bar colour for the selected index.
  always_comb begin
    o_rgb = bar_colour(w_bar);
  end

endmodule
`endif

// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen: raster timing + two-stage pixel pipeline for the
// ADV7513 parallel RGB input. Stage 1 requests pixels by (x,y) one cycle after
// the counters; stage 2 registers DE/HSYNC/VSYNC/RGB together two cycles after
// the counters so every output is mutually aligned.
// Optional feature macro: HDMI_TEST_PATTERN_EN (internal colour bars when
// pattern_sel=1). Without it pattern_sel is ignored and no bar logic exists.
module hdmi_video_timing_gen
  import hdmi_video_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        pattern_sel,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic [23:0] pixel_rgb,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        running
);

  // Line/frame landmarks, all in counter units.
  localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
  localparam coord_t H_SYNC_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t H_LAST     = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
  localparam coord_t V_SYNC_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t V_LAST     = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam logic SYNC_IDLE = ~SYNC_POL;
  localparam rgb_t RGB_BLACK = 24'h000000;

  // Raster FSM and counters.
  state_t r_state;
  state_t w_state_next;
  coord_t r_hc;
  coord_t r_vc;
  coord_t w_hc_next;
  coord_t w_vc_next;

  // Counter decode.
  logic w_run;
  logic w_h_last;
  logic w_v_last;
  logic w_h_act;
  logic w_v_act;
  logic w_h_sync;
  logic w_v_sync;
  logic w_origin;

  // Stage 1: request stage.
  logic   r_pix_req;
  coord_t r_pix_x;
  coord_t r_pix_y;
  logic   r_frame_start;
  logic   r_s1_hsync;
  logic   r_s1_vsync;

  // Stage 2: bus stage.
  logic r_de;
  logic r_hsync;
  logic r_vsync;
  rgb_t r_rgb;
  rgb_t w_src_rgb;
  rgb_t w_rgb_next;

  assign w_run    = (r_state == RUN);
  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);
  assign w_h_act  = (r_hc < H_ACT_END);
  assign w_v_act  = (r_vc < V_ACT_END);
  assign w_h_sync = (r_hc >= H_SYNC_BEG) && (r_hc < H_SYNC_END);
  assign w_v_sync = (r_vc >= V_SYNC_BEG) && (r_vc < V_SYNC_END);
  assign w_origin = (r_hc == '0) && (r_vc == '0);

  // FSM state and raster counters register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_hc    <= '0;
      r_vc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_hc    <= w_hc_next;
      r_vc    <= w_vc_next;
    end
  end

  // Next state and counter advance; a stop request only takes effect at the
  // last pixel of the frame so frames are never truncated.
  always_comb begin
    w_state_next = r_state;
    w_hc_next    = '0;
    w_vc_next    = '0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_h_last) begin
          w_hc_next = '0;
          w_vc_next = w_v_last ? coord_t'(0) : r_vc + coord_t'(1);
        end else begin
          w_hc_next = r_hc + coord_t'(1);
          w_vc_next = r_vc;
        end
        if (w_h_last && w_v_last && !en) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Stage 1: decode counters into pixel request, frame marker and raw syncs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix_req     <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
      r_s1_hsync    <= SYNC_IDLE;
      r_s1_vsync    <= SYNC_IDLE;
    end else begin
      r_pix_req     <= w_run && w_h_act && w_v_act;
      r_pix_x       <= r_hc;
      r_pix_y       <= r_vc;
      r_frame_start <= w_run && w_origin;
      r_s1_hsync    <= (w_run && w_h_sync) ? SYNC_POL : SYNC_IDLE;
      r_s1_vsync    <= (w_run && w_v_sync) ? SYNC_POL : SYNC_IDLE;
    end
  end

`ifdef HDMI_TEST_PATTERN_EN
  logic [23:0] w_bar_rgb;

  video_colour_bars #(
    .H_ACTIVE(H_ACTIVE)
  ) u_colour_bars (
    .i_pix_x(r_pix_x),
    .o_rgb  (w_bar_rgb)
  );

  assign w_src_rgb = pattern_sel ? rgb_t'(w_bar_rgb) : rgb_t'(pixel_rgb);
`else
  // pattern_sel has no function in this build.
  logic w_unused_pattern_sel;
  assign w_unused_pattern_sel = pattern_sel;
  assign w_src_rgb            = rgb_t'(pixel_rgb);
`endif

  // Blank the colour bus outside the active area.
  assign w_rgb_next = r_pix_req ? w_src_rgb : RGB_BLACK;

  // Stage 2: register DE, syncs and RGB together for the transmitter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_de    <= 1'b0;
      r_hsync <= SYNC_IDLE;
      r_vsync <= SYNC_IDLE;
      r_rgb   <= RGB_BLACK;
    end else begin
      r_de    <= r_pix_req;
      r_hsync <= r_s1_hsync;
      r_vsync <= r_s1_vsync;
      r_rgb   <= w_rgb_next;
    end
  end

  assign pix_req     = r_pix_req;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign running     = w_run;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// tb_hdmi_video_timing_gen: directed bench for hdmi_video_timing_gen using a
// reduced raster (25x15 clocks) so whole frames are cheap. Expected pixels are
// pushed to a scoreboard when the upstream pixel is driven and popped on DE.
`timescale 1ns/1ps
module tb_hdmi_video_timing_gen;

  localparam int H_ACTIVE   = 16;
  localparam int H_FP       = 2;
  localparam int H_SYNC     = 4;
  localparam int H_BP       = 3;
  localparam int V_ACTIVE   = 8;
  localparam int V_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 3;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME      = H_TOTAL * V_TOTAL;
  localparam int ACTIVE_PIX = H_ACTIVE * V_ACTIVE;

`ifdef HDMI_TEST_PATTERN_EN
  localparam logic [23:0] EXP_X0  = 24'hFFFFFF;
  localparam logic [23:0] EXP_X2  = 24'hFFFF00;
  localparam logic [23:0] EXP_X15 = 24'h000000;
`else
  localparam logic [23:0] EXP_X0  = 24'h0000A5;
  localparam logic [23:0] EXP_X2  = 24'h0200A5;
  localparam logic [23:0] EXP_X15 = 24'h0F00A5;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic        pattern_sel;
  logic [23:0] pixel_rgb;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb;
  logic        running;

  hdmi_video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .pattern_sel(pattern_sel),
    .pix_req    (pix_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pixel_rgb  (pixel_rgb),
    .frame_start(frame_start),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .rgb        (rgb),
    .running    (running)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          fs_cyc = 0;
  int          de_cnt, preq_cnt, fs_cnt, hs_len, hs_pulses, act_lines, vs_low;
  logic        line_had_de;
  logic        pat_mode;
  logic [11:0] exp_x, exp_y;
  logic [23:0] sb[$];
  logic [23:0] bar_lut[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    de_cnt    = 0;
    preq_cnt  = 0;
    fs_cnt    = 0;
    hs_pulses = 0;
    act_lines = 0;
    vs_low    = 0;
  endtask

  // One clock: sample on the falling edge, run scoreboard and raster stats,
  // then drive the upstream pixel for the next rising edge.
  task automatic step();
    logic [23:0] exp_rgb;
    int          idx;
    @(negedge clk);
    cyc++;
    if (de) begin
      de_cnt++;
      line_had_de = 1'b1;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_rgb = sb.pop_front();
        check("rgb_pixel", 32'(rgb), 32'(exp_rgb));
      end
    end else begin
      check("rgb_blank", 32'(rgb), 32'h0);
    end
    if (frame_start) begin
      fs_cnt++;
      fs_cyc = cyc;
      check("fs_at_origin", {7'd0, pix_req, pix_y, pix_x}, {7'd0, 1'b1, 24'h0});
      exp_x = '0;
      exp_y = '0;
    end
    if (pix_req) begin
      preq_cnt++;
      check("pix_xy", {8'd0, pix_y, pix_x}, {8'd0, exp_y, exp_x});
      idx = (int'(exp_x) * 8) / H_ACTIVE;
      if (pat_mode) exp_rgb = bar_lut[idx[2:0]];
      else          exp_rgb = {exp_x[7:0], exp_y[7:0], 8'hA5};
      sb.push_back(exp_rgb);
      pixel_rgb = {pix_x[7:0], pix_y[7:0], 8'hA5};
      if (exp_x == 12'(H_ACTIVE - 1)) begin
        exp_x = '0;
        exp_y = exp_y + 12'd1;
      end else begin
        exp_x = exp_x + 12'd1;
      end
    end else begin
      pixel_rgb = 24'($urandom);
    end
    if (hsync == 1'b0) begin
      hs_len++;
    end else if (hs_len != 0) begin
      check("hsync_width", hs_len, H_SYNC);
      hs_pulses++;
      if (line_had_de) act_lines++;
      line_had_de = 1'b0;
      hs_len      = 0;
    end
    if (vsync == 1'b0) vs_low++;
  endtask

  task automatic wait_frame_start(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step();
      if (frame_start) break;
    end
    check(tag, 32'(frame_start), 32'd1);
  endtask

  task automatic wait_stopped(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step();
      if (!running) break;
    end
    check(tag, 32'(running), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int found;
    bar_lut[0] = 24'hFFFFFF; bar_lut[1] = 24'hFFFF00;
    bar_lut[2] = 24'h00FFFF; bar_lut[3] = 24'h00FF00;
    bar_lut[4] = 24'hFF00FF; bar_lut[5] = 24'hFF0000;
    bar_lut[6] = 24'h0000FF; bar_lut[7] = 24'h000000;
    resetn = 1'b0; en = 1'b0; pattern_sel = 1'b0; pixel_rgb = '0;
    pat_mode = 1'b0; exp_x = '0; exp_y = '0;
    hs_len = 0; line_had_de = 1'b0;
    clear_stats();

    // Reset state.
    #22;
    check("rst_pix_req", 32'(pix_req), 32'd0);
    check("rst_pix_xy", {8'd0, pix_y, pix_x}, 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_de", 32'(de), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_syncs", {30'd0, hsync, vsync}, 32'd3);
    @(negedge clk);
    resetn = 1'b1;

    // en=0 for 100 cycles: nothing moves.
    clear_stats();
    repeat (100) step();
    check("idle_de_cnt", de_cnt, 0);
    check("idle_preq_cnt", preq_cnt, 0);
    check("idle_running", 32'(running), 32'd0);
    check("idle_syncs", {30'd0, hsync, vsync}, 32'd3);

    // Full frame: timing totals and first pixel.
    en = 1'b1;
    wait_frame_start(8, "fs_first");
    check("running_on", 32'(running), 32'd1);
    clear_stats();
    start = cyc;
    step();
    check("first_de", 32'(de), 32'd1);
    check("first_rgb", 32'(rgb), 32'h0000A5);
    wait_frame_start(FRAME + 10, "fs_second");
    check("frame_period", cyc - start, FRAME);
    check("frame_de_cnt", de_cnt, ACTIVE_PIX);
    check("frame_hs_pulses", hs_pulses, V_TOTAL);
    check("frame_active_lines", act_lines, V_ACTIVE);
    check("frame_vsync_low", vs_low, V_SYNC * H_TOTAL);

    // Drop en mid-frame: frame completes, then stops.
    clear_stats();
    start = fs_cyc;
    found = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (pix_req && pix_y == 12'd5) begin
        found = 1;
        break;
      end
    end
    check("en_drop_point", found, 1);
    en = 1'b0;
    wait_stopped(FRAME, "run_stops");
    check("stop_cycle", cyc - start, FRAME - 1);
    check("drop_frame_de", de_cnt, ACTIVE_PIX);
    clear_stats();
    repeat (2 * FRAME) step();
    check("stopped_de", de_cnt, 0);
    check("stopped_preq", preq_cnt, 0);
    check("stopped_fs", fs_cnt, 0);
    check("stopped_hs", hs_pulses + vs_low, 0);
    check("stopped_syncs", {30'd0, hsync, vsync}, 32'd3);

    // Re-raise: frame_start one cycle after the (0,0) counter cycle.
    en = 1'b1;
    step();
    check("rerun_running", 32'(running), 32'd1);
    check("rerun_fs_early", 32'(frame_start), 32'd0);
    step();
    check("rerun_fs", 32'(frame_start), 32'd1);

    // Asynchronous reset in the middle of an hsync pulse.
    found = 0;
    for (int i = 0; i < 2 * H_TOTAL; i++) begin
      step();
      if (!hsync) begin
        found = 1;
        break;
      end
    end
    check("hsync_seen", found, 1);
    step();
    #2 resetn = 1'b0;
    #1;
    check("arst_hsync", 32'(hsync), 32'd1);
    check("arst_vsync", 32'(vsync), 32'd1);
    check("arst_de", 32'(de), 32'd0);
    check("arst_rgb", 32'(rgb), 32'd0);
    check("arst_pix_req", 32'(pix_req), 32'd0);
    check("arst_pix_xy", {8'd0, pix_y, pix_x}, 32'd0);
    check("arst_running", 32'(running), 32'd0);
    en = 1'b0;
    sb.delete();
    hs_len = 0;
    line_had_de = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    clear_stats();
    repeat (20) step();
    check("post_rst_de", de_cnt, 0);
    check("post_rst_running", 32'(running), 32'd0);

    // pattern_sel=1: colour bars when built with the pattern, else ignored.
    pattern_sel = 1'b1;
`ifdef HDMI_TEST_PATTERN_EN
    pat_mode = 1'b1;
`endif
    en = 1'b1;
    wait_frame_start(8, "fs_pattern");
    clear_stats();
    step();
    check("pat_x0", 32'(rgb), 32'(EXP_X0));
    repeat (2) step();
    check("pat_x2", 32'(rgb), 32'(EXP_X2));
    repeat (13) step();
    check("pat_x15", 32'(rgb), 32'(EXP_X15));
    wait_frame_start(FRAME + 10, "fs_pattern_end");
    check("pat_frame_de", de_cnt, ACTIVE_PIX);
    en = 1'b0;
    wait_stopped(FRAME + 10, "final_stop");
    pattern_sel = 1'b0;
    pat_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
